// File: rtl/fp_div_nr.sv
// fp_div_nr: sequential IEEE-754 single-precision divider, q = a / b.
// Newton-Raphson reciprocal of |b| from a bit-trick seed, then scaled by a.
module fp_div_nr #(
  parameter int          ITERS      = 3,
  parameter logic [31:0] SEED_MAGIC = 32'h7EF311C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_MUL_T = 3'd2;
  localparam logic [2:0] S_SUB   = 3'd3;
  localparam logic [2:0] S_MUL_X = 3'd4;
  localparam logic [2:0] S_FINAL = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] ITERS_W = 3'(ITERS);

  // Round-to-nearest-even multiply; zero exponent flushes, overflow saturates to inf.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic              s, g, st;
    logic [47:0]       ma, mb, p;
    logic signed [9:0] e;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic [31:0]       r;
    s  = x[31] ^ y[31];
    ma = {24'd0, 1'b1, x[22:0]};
    mb = {24'd0, 1'b1, y[22:0]};
    p  = ma * mb;
    e  = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]}; e = e + 10'sd1;
    end else begin
      mr = mr;
    end
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0)  r = {s, 31'd0};
    else if (e >= 10'sd255)                     r = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0 || !mr[23])            r = {s, 31'd0};
    else                                        r = {s, e[7:0], mr[22:0]};
    return r;
  endfunction

  // Round-to-nearest-even add/subtract (op=1 subtracts y), zero-flushing.
  function automatic logic [31:0] fp_addsub(input logic [31:0] x, input logic [31:0] y, input logic op);
    logic [31:0]       yy, big, sml, r;
    logic [7:0]        d;
    logic [26:0]       mb, ms, mask;
    logic [27:0]       s;
    logic signed [9:0] e;
    logic              g, st;
    logic [23:0]       m;
    logic [24:0]       mr;
    yy = {y[31] ^ op, y[30:0]};
    if (x[30:0] >= yy[30:0]) begin big = x;  sml = yy; end
    else                     begin big = yy; sml = x;  end
    d    = big[30:23] - sml[30:23];
    mb   = {1'b1, big[22:0], 3'b000};
    ms   = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    mask = 27'd0;
    if (d >= 8'd27) begin
      ms = {26'd0, |ms};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      ms   = (ms >> d) | {26'd0, |(ms & mask)};
    end
    e = $signed({2'b00, big[30:23]});
    if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, ms};
    else                    s = {1'b0, mb} - {1'b0, ms};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]}; e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && s != 28'd0) begin
          s = s << 1; e = e - 10'sd1;
        end else begin
          s = s;
        end
      end
    end
    m  = s[26:3]; g = s[2]; st = |s[1:0];
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]}; e = e + 10'sd1;
    end else begin
      mr = mr;
    end
    if (big[30:23] == 8'd0)             r = 32'd0;
    else if (e >= 10'sd255)             r = {big[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0 || !mr[23])    r = 32'd0;
    else                                r = {big[31], e[7:0], mr[22:0]};
    return r;
  endfunction

  logic [2:0]  r_state, r_cnt;
  logic [30:0] r_a, r_b;
  logic        r_sign, r_a_zero, r_a_inf, r_a_nan, r_b_zero, r_b_inf, r_b_nan;
  logic [31:0] r_x, r_t, r_u, r_result;
  logic        r_busy, r_valid, r_dz, r_inv;
  logic [31:0] w_ma, w_mb, w_mul, w_add, w_res;
  logic        w_dz, w_inv;
  logic [2:0]  w_cnt_nx;

  assign w_cnt_nx = r_cnt + 3'd1;

  // Steer the single shared multiplier to the operands each state needs.
  always_comb begin
    w_ma = r_x;
    w_mb = r_x;
    case (r_state)
      S_MUL_T: begin w_ma = {1'b0, r_b}; w_mb = r_x; end
      S_MUL_X: begin w_ma = r_x;         w_mb = r_u; end
      S_FINAL: begin w_ma = {1'b0, r_a}; w_mb = r_x; end
      default: begin w_ma = r_x;         w_mb = r_x; end
    endcase
  end

  assign w_mul = fp_mul(w_ma, w_mb);
  assign w_add = fp_addsub(32'h4000_0000, r_t | 32'h8000_0000, 1'b0);

  // Special-case overrides in priority order, else the computed quotient.
  always_comb begin
    w_res = {r_sign, w_mul[30:0]};
    w_dz  = 1'b0;
    w_inv = 1'b0;
    if (r_a_nan || r_b_nan || (r_a_zero && r_b_zero) || (r_a_inf && r_b_inf)) begin
      w_res = 32'h7FC0_0000;
      w_inv = 1'b1;
    end else if (r_b_zero) begin
      w_res = {r_sign, 31'h7F80_0000};
      w_dz  = !r_a_inf;
    end else if (r_a_inf) begin
      w_res = {r_sign, 31'h7F80_0000};
    end else if (r_a_zero || r_b_inf) begin
      w_res = {r_sign, 31'd0};
    end else begin
      w_res = {r_sign, w_mul[30:0]};
    end
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;  r_cnt <= 3'd0;
      r_a <= 31'd0;  r_b <= 31'd0;  r_sign <= 1'b0;
      r_a_zero <= 1'b0;  r_a_inf <= 1'b0;  r_a_nan <= 1'b0;
      r_b_zero <= 1'b0;  r_b_inf <= 1'b0;  r_b_nan <= 1'b0;
      r_x <= 32'd0;  r_t <= 32'd0;  r_u <= 32'd0;  r_result <= 32'd0;
      r_busy <= 1'b0;  r_valid <= 1'b0;  r_dz <= 1'b0;  r_inv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_a      <= a[30:0];
            r_b      <= b[30:0];
            r_sign   <= a[31] ^ b[31];
            r_a_zero <= (a[30:23] == 8'd0);
            r_a_inf  <= (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
            r_a_nan  <= (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
            r_b_zero <= (b[30:23] == 8'd0);
            r_b_inf  <= (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
            r_b_nan  <= (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
            r_dz     <= 1'b0;
            r_inv    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_SEED;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SEED: begin
          r_x     <= SEED_MAGIC - {1'b0, r_b};
          r_cnt   <= 3'd0;
          r_state <= S_MUL_T;
        end
        S_MUL_T: begin
          r_t     <= w_mul;
          r_state <= S_SUB;
        end
        S_SUB: begin
          r_u     <= w_add;
          r_state <= S_MUL_X;
        end
        S_MUL_X: begin
          r_x     <= w_mul;
          r_cnt   <= w_cnt_nx;
          r_state <= (w_cnt_nx < ITERS_W) ? S_MUL_T : S_FINAL;
        end
        S_FINAL: begin
          r_result <= w_res;
          r_dz     <= w_dz;
          r_inv    <= w_inv;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign result      = r_result;
  assign div_by_zero = r_dz;
  assign invalid     = r_inv;
endmodule

// File: doc/fp_div_nr.md
Name: fp_div_nr

Overview:
- Sequential IEEE-754 single-precision divider for the float_ops ALU: q = a / b.
- Computes a reciprocal of |b| by Newton-Raphson refinement, x(k+1) = x(k)·(2 − |b|·x(k)), starting from a bit-trick seed.
- Multiplies the refined reciprocal by a to form the quotient.
- Owns the sequencing and handshake: it is the multi-cycle controller side of the combinational refinement step. Internally it time-shares one Mult and one Add_Sub instance across states.

Parameters:
- ITERS, 3: number of Newton-Raphson refinement passes (1..7).
- SEED_MAGIC, 32'h7EF311C3: constant for the reciprocal seed; x0 = SEED_MAGIC − {1'b0, b[30:0]}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  32  dividend, IEEE-754 single; captured on accepted start.
- b  input  32  divisor, IEEE-754 single; captured on accepted start.
- busy  output  1  high from the cycle after start is accepted until valid.
- valid  output  1  one-cycle pulse; result is final.
- result  output  32  quotient; held from valid until the next accepted start.
- div_by_zero  output  1  sticky flag for the last operation (b = ±0 with a finite and nonzero); updated with valid.
- invalid  output  1  sticky flag for the last operation (NaN input, 0/0, inf/inf); updated with valid.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, valid, div_by_zero, invalid = 0; result = 32'h0; internal registers cleared. An operation in flight is discarded and no valid is produced.
- Input classification (done at capture):
  - exp==0 → zero; denormals are flushed to signed zero.
  - exp==255, mantissa==0 → inf.
  - exp==255, mantissa!=0 → NaN.
- States: IDLE → SEED → {MUL_T → SUB → MUL_X} × ITERS → FINAL → DONE → IDLE. Each state lasts exactly one cycle.
  - IDLE: on start=1, capture a, b, and the class bits; go to SEED.
  - SEED: x ← SEED_MAGIC − {0, b[30:0]}; iteration counter ← 0.
  - MUL_T: t ← Mult(|b|, x).
  - SUB: u ← Add_Sub(32'h4000_0000, t | 32'h8000_0000, op=0), i.e. 2 − t.
  - MUL_X: x ← Mult(x, u); counter increments. Go to MUL_T while counter < ITERS, else FINAL.
  - FINAL: q ← Mult({0, a[30:0]}, x); sign ← a[31] ^ b[31].
  - DONE: result ← special-case override if any, else {sign, q[30:0]}; flags updated; valid=1; busy=0.
- Latency: accepted start at cycle N gives valid at cycle N + 3·ITERS + 3 (N+12 at default). Latency is constant for all operands, including special cases.
- busy: 1 in SEED through FINAL; 0 in IDLE and DONE.
- start while busy or in DONE: ignored, with no effect on operands.
- start in the IDLE cycle immediately after DONE: accepted, so back-to-back throughput is one op per 3·ITERS+4 cycles.
- Special-case overrides, applied in priority order:
  1. Any NaN, 0/0, or inf/inf: result=32'h7FC0_0000, invalid=1.
  2. b=±0: result = sign·inf (32'h7F80_0000 | sign<<31), div_by_zero=1.
  3. a=±inf: result = signed inf.
  4. a=±0 or b=±inf: result = signed zero.
- Normal-operand accuracy with ITERS≥3: within ±2 ulp of the correctly rounded quotient.
- Quotient overflow/underflow follows Mult's saturation behaviour. No extra flag is raised.
- The flags describe only the most recent completed operation; they are cleared when the next start is accepted.

Test Plan:
- Reset, then a=0x40C0_0000 (6.0), b=0x4040_0000 (3.0), start for 1 cycle → busy high 11 cycles; valid at start+12; result within 2 ulp of 0x4000_0000; flags 0.
- a=0xC0F0_0000 (−7.5), b=0x4020_0000 (2.5) → result within 2 ulp of 0xC040_0000 (−3.0); sign correct.
- a=0x3F80_0000, b=0x8000_0000 (−0) → result=0xFF80_0000, div_by_zero=1, invalid=0, latency still 12.
- a=0x7FC0_0001 (NaN), b=0x3F80_0000 → result=0x7FC0_0000, invalid=1. Then a=0, b=0 → 0x7FC0_0000, invalid=1.
- Start accepted, second start with different operands at cycle +5 → single valid at +12 with the first operands' quotient; no second valid.
- Start accepted, rst_n low at cycle +6 → busy and valid drop immediately, result=0. After release, a fresh op (1.0/4.0) → result within 2 ulp of 0x3E80_0000 at +12.
